tinyqv_instr_prefetch: RTL
==========================

# tinyqv_instr_prefetch

Instruction prefetch and alignment buffer that feeds `tinyqv_decoder`. It accepts a stream of 16-bit halfwords from the memory interface and buffers them. It then assembles aligned 16-bit (compressed) and 32-bit instructions and presents one instruction at a time with its length and PC. It also drives the next fetch address and is flushed on any control-flow redirect.

## Interface

Parameters:
- `DEPTH` — default 4 — buffer capacity in halfwords; legal range 2..8.

Ports:
- `clk` — input, 1 — clock.
- `rstn` — input, 1 — asynchronous active-low reset.
- `data_in` — input, 16 — halfword from memory, little-endian order.
- `data_in_valid` — input, 1 — `data_in` is present this cycle.
- `data_in_ready` — output, 1 — buffer can accept a halfword this cycle.
- `fetch_addr` — output, 24 — byte address of the next halfword to request; bit 0 is always 0.
- `instr` — output, 32 — instruction at the head of the buffer.
- `instr_len` — output, 3 — 2 or 4 bytes, same encoding as the decoder's `instr_len`.
- `instr_pc` — output, 24 — byte address of `instr`.
- `instr_valid` — output, 1 — `instr`, `instr_len` and `instr_pc` are valid.
- `instr_ready` — input, 1 — consumer takes the instruction this cycle.
- `flush` — input, 1 — discard all buffered data and redirect.
- `flush_pc` — input, 24 — new PC on redirect; bit 0 is ignored and treated as 0.

## Operation

- Storage is a FIFO of `DEPTH` halfwords plus a count register (0..`DEPTH`). The head is `hw0` and the next entry is `hw1`.
- Length rule: if `hw0[1:0] == 2'b11` the instruction is 32-bit, otherwise it is 16-bit.
- `instr_valid` is 1 when count ≥ 2, or when count == 1 and the head instruction is 16-bit.
- Instruction output:
  - 32-bit: `instr = {hw1, hw0}`, `instr_len = 4`.
  - 16-bit: `instr = {16'h0, hw0}`, `instr_len = 2`.
  - When `instr_valid` is 0: `instr = 0` and `instr_len = 0`.
- Push: on `data_in_valid && data_in_ready`, append `data_in` and advance `fetch_addr` by 2.
- `data_in_ready = (count < DEPTH)`. It does not depend on a pop in the same cycle.
- Pop: on `instr_valid && instr_ready`, remove 1 or 2 halfwords and advance `instr_pc` by `instr_len`.
- Simultaneous push and pop in one cycle is legal. The count change is +1 − popped halfwords.
- Flush:
  - Count becomes 0, `instr_pc` becomes `flush_pc & ~1`, and `fetch_addr` becomes `flush_pc & ~1`.
  - Flush has priority: any push or pop in the same cycle is ignored and `data_in` is discarded.
- Address arithmetic is modulo 2^24. `fetch_addr` and `instr_pc` wrap from 0xFFFFFE to 0x000000.
- A 32-bit instruction split across a halfword boundary waits, with `instr_valid` = 0, until its second halfword arrives.

## Timing

- Reset values:
  - count 0, `instr_valid` 0, `instr` 0, `instr_len` 0.
  - `instr_pc` 0, `fetch_addr` 0, `data_in_ready` 1.
- All state updates occur on the rising edge of `clk`. Reset is asynchronous, with synchronous deassertion handled upstream.
- Latency: a halfword accepted at edge N can appear in `instr` from cycle N+1. There is no combinational path from `data_in` to `instr`.
- All outputs are functions of registered state only. There are no combinational paths from `instr_ready`, `data_in_valid` or `flush` to any output.
- Throughput: one halfword in per cycle, and one instruction out per cycle when data is available.
- Flush asserted at edge N: `instr_valid` = 0 in cycle N+1, and `fetch_addr` = new value in cycle N+1.
- Reset asserted mid-operation returns every output to its reset value immediately.

## Test plan

- **Compressed stream.** After reset, push 0x4501, then 0x0505. Required response:
  - cycle 1: `instr` = 0x00004501, len 2, pc 0x000000.
  - after one pop: `instr` = 0x00000505, pc 0x000002.
  - `fetch_addr` = 0x000004.
- **32-bit assembly and split wait.** Push 0x0513 only; `instr_valid` must stay 0. Then push 0x0010. Required: `instr` = 0x00100513, len 4, pc 0. After the pop, pc = 4 and count = 0.
- **Mixed sequence with back-pressure.**
  - Push 0x0293, 0x0050, 0x4185, 0x00B3 with `instr_ready` = 0. Required: `data_in_ready` falls after the 4th halfword (DEPTH = 4).
  - Then hold `instr_ready` = 1. Required outputs in order: 0x00500293 (len 4), 0x00004185 (len 2), then `instr_valid` = 0 until 0x00B3's upper half arrives.
- **Simultaneous push and pop.** With count = 3 and a 16-bit head, push and pop in the same cycle. Required: count becomes 3 and pc advances by 2.
- **Flush.** With 3 halfwords buffered and a push in the same cycle as `flush` = 1 and `flush_pc` = 0x000123. Required: count = 0, `instr_pc` = 0x000122, `fetch_addr` = 0x000122, the pushed data is dropped, and `instr_valid` = 0 the next cycle.
- **Wrap-around.** Flush to 0xFFFFFC, then push 0x0001, 0x0001, 0x0001. Required: `fetch_addr` goes 0xFFFFFE → 0x000000 → 0x000002, and `instr_pc` wraps to 0x000000 on the 3rd instruction.

Source files
------------

// File: rtl/tinyqv_instr_prefetch.sv
// ---------------------------------------------------------------------------
// tinyqv_instr_prefetch
//
// Purpose:
//   Instruction prefetch and alignment buffer in front of tinyqv_decoder.
//   Halfwords arrive from memory in little-endian order and are stored in a
//   small circular FIFO. The head of the FIFO is presented as one aligned
//   instruction at a time: 16-bit (compressed) or 32-bit, with its length
//   and PC. A redirect (flush) empties the buffer and restarts both the
//   fetch address and the instruction PC at the new target.
//
// Ports:
//   clk           - clock
//   rstn          - asynchronous active-low reset
//   data_in       - halfword from memory
//   data_in_valid - data_in is present this cycle
//   data_in_ready - buffer has room for one more halfword
//   fetch_addr    - byte address of the next halfword to request (bit 0 = 0)
//   instr         - instruction at the head of the buffer
//   instr_len     - 2 or 4 bytes, 0 when instr_valid is low
//   instr_pc      - byte address of instr
//   instr_valid   - instr / instr_len / instr_pc are valid
//   instr_ready   - consumer takes the instruction this cycle
//   flush         - discard all buffered data and redirect
//   flush_pc      - redirect target; bit 0 is ignored
// ---------------------------------------------------------------------------
module tinyqv_instr_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [23:0] fetch_addr,
  output logic [31:0] instr,
  output logic [2:0]  instr_len,
  output logic [23:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush,
  input  logic [23:0] flush_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW:0]   DEPTH_P = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]   buf_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [15:0] hw0;
  logic [15:0] hw1;
  logic        head_is_32;
  logic        valid;
  logic        push;
  logic [1:0]  pop_n;

  // Circular pointer advance by 0..2 entries. DEPTH need not be a power of
  // two, so the wrap is done explicitly rather than by natural overflow.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p,
                                            input logic [1:0]    n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW + 1)'(n);
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PW-1:0];
  endfunction

  // hw1 may be stale when only one halfword is buffered; it is only ever
  // used for a 32-bit head, which requires two halfwords to be valid.
  assign hw0        = buf_q[rd_ptr];
  assign hw1        = buf_q[ptr_add(rd_ptr, 2'd1)];
  assign head_is_32 = (hw0[1:0] == 2'b11);

  // Ready depends only on the registered count, never on a same-cycle pop,
  // so there is no path from instr_ready to data_in_ready.
  assign data_in_ready = (count < DEPTH_C);
  assign push          = data_in_valid && data_in_ready;
  assign instr_valid   = valid;

  // Instruction assembly from the head of the buffer. Everything here is
  // derived from registered state; instr_ready only selects how many
  // halfwords leave the buffer on the next edge.
  always_comb begin
    valid     = 1'b0;
    instr     = 32'h0;
    instr_len = 3'd0;
    pop_n     = 2'd0;
    if ((count >= CW'(2)) || ((count == CW'(1)) && !head_is_32)) begin
      valid = 1'b1;
    end
    if (valid) begin
      if (head_is_32) begin
        instr     = {hw1, hw0};
        instr_len = 3'd4;
      end else begin
        instr     = {16'h0, hw0};
        instr_len = 3'd2;
      end
      if (instr_ready) begin
        pop_n = head_is_32 ? 2'd2 : 2'd1;
      end
    end
  end

  // Buffer, pointers and address registers. Flush wins over everything in
  // the same cycle, so a halfword offered alongside a flush is dropped and
  // the head instruction is not consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 16'h0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= 24'h0;
      instr_pc   <= 24'h0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= flush_pc & 24'hFFFFFE;
      instr_pc   <= flush_pc & 24'hFFFFFE;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= data_in;
        wr_ptr        <= ptr_add(wr_ptr, 2'd1);
        fetch_addr    <= fetch_addr + 24'd2;
      end
      if (pop_n != 2'd0) begin
        rd_ptr   <= ptr_add(rd_ptr, pop_n);
        instr_pc <= instr_pc + 24'(instr_len);
      end
      count <= count + CW'(push) - CW'(pop_n);
    end
  end

endmodule
